button_event_gen: RTL and testbench
===================================

// Module: button_event_gen
// PURPOSE
//  Turns raw Go Board push-button inputs into clean, single-cycle event pulses for the
//  counter/display stages downstream. It provides, per channel:
//   - a synchronised, debounced button level,
//   - a press pulse, with hold-to-repeat press pulses,
//   - a release pulse.
//  Consumers such as click counters and menu logic run on CLK and act on the
//  1-cycle pulses. They never use button edges as clocks.
// PARAMETERS
//  N_BTN            2          number of independent button channels
//  DEBOUNCE_CYCLES  250000     cycles a new level must be stable before acceptance (10 ms @ 25 MHz)
//  REPEAT_EN        1          1: hold-to-repeat enabled; 0: one press pulse per press
//  REPEAT_DELAY     12500000   cycles from first press pulse to first repeat pulse (500 ms)
//  REPEAT_RATE      2500000    cycles between subsequent repeat pulses (100 ms)
// PORTS
//  CLK          in   1      system clock, 25 MHz
//  RST          in   1      synchronous, active-high reset
//  BTN_IN       in   N_BTN  raw asynchronous buttons, active-high
//  BTN_LEVEL    out  N_BTN  debounced level per channel (registered)
//  BTN_PRESS    out  N_BTN  1-cycle pulse on accepted press and on each repeat
//  BTN_RELEASE  out  N_BTN  1-cycle pulse on accepted release
// BEHAVIOUR
//  - Reset
//     - All outputs are 0; synchroniser flops, counters and FSM clear; debounced level is 0.
//     - RST wins over every other event in the same cycle.
//  - Synchroniser
//     - Each BTN_IN bit passes through a 2-FF synchroniser (sync_q).
//  - Debounce
//     - Counter resets to 0 whenever sync_q == BTN_LEVEL, else it increments.
//     - When the counter reaches DEBOUNCE_CYCLES-1 while still mismatched, BTN_LEVEL toggles
//       on the next edge and the counter clears.
//     - Latency: BTN_LEVEL changes 2+DEBOUNCE_CYCLES cycles after the first cycle the new
//       raw level is sampled.
//     - A glitch shorter than DEBOUNCE_CYCLES causes no level change and no pulse.
//  - FSM per channel: IDLE, DELAY, REPEAT
//     - IDLE -> DELAY on a level rise. BTN_PRESS=1 in the same cycle BTN_LEVEL goes 1;
//       the repeat counter loads REPEAT_DELAY-1.
//     - DELAY: counts down while the level is 1. At 0: BTN_PRESS pulse, load REPEAT_RATE-1,
//       go to REPEAT.
//     - REPEAT: counts down; at 0: BTN_PRESS pulse and reload REPEAT_RATE-1.
//     - Any state -> IDLE on a level fall, with BTN_RELEASE=1 in the same cycle BTN_LEVEL
//       goes 0. A release in DELAY produces no repeat pulse.
//     - REPEAT_EN=0: the FSM stays in DELAY until release and never emits repeats.
//  - Pulses
//     - Pulses are registered outputs.
//     - BTN_PRESS and BTN_RELEASE are never both 1 on one channel in the same cycle.
//     - Pulse spacing is at least 1 idle cycle whenever REPEAT_RATE>=2.
//  - Channels
//     - Channels are fully independent; simultaneous presses give simultaneous pulses.
//       Arbitration is the consumer's job.
//  - Reset mid-operation
//     - A button held through reset is re-debounced from level 0.
//     - After RST falls, it yields a fresh press pulse 2+DEBOUNCE_CYCLES cycles later.
//  - Widths
//     - Counters are $clog2(max+1) bits and unsigned.
//     - The repeat counter is sized for max(REPEAT_DELAY, REPEAT_RATE).
//     - No wrap occurs: every reload happens at 0.
// STRUCTURE
//  - go_board_defs.vh holds CLK_HZ=25000000, the ms-to-cycles conversion macro, and the
//    FSM state encodings (IDLE=2'd0, DELAY=2'd1, REPEAT=2'd2).
//  - One sub-module, btn_event_channel, implements sync + debounce + FSM for a single bit.
//  - The top instantiates it N_BTN times in a generate loop; no cross-channel logic.
// TESTING
//  - Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8.
//  1. BTN_IN[0] rises at cycle 10, held -> BTN_LEVEL[0] and BTN_PRESS[0] both 1 at cycle 16;
//     BTN_PRESS[0] is 0 at cycle 17.
//  2. 3-cycle high glitch on BTN_IN[1] -> BTN_LEVEL[1] stays 0; no PRESS or RELEASE.
//  3. Hold 60 cycles after the press at cycle 16 -> repeat PRESS pulses at cycles 36, 44, 52, 60, 68.
//  4. Release during DELAY -> BTN_RELEASE pulses 6 cycles after the raw fall; no repeat pulse.
//  5. RST for 2 cycles mid-REPEAT with the button held -> outputs 0 during reset;
//     a new PRESS 6 cycles after RST falls.
//  6. Both channels pressed in the same cycle; REPEAT_EN=0 run -> identical-cycle PRESS on
//     both channels; no repeats over 100 held cycles.

Source files
------------

// File: rtl/button_event_gen_pkg.sv
// Shared definitions for the button event generator: clock rate, time
// conversion helpers and the per-channel FSM state encoding.
package button_event_gen_pkg;

    localparam int CLK_HZ = 25000000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } btn_state_t;

    // Convert a duration in milliseconds into CLK cycles.
    function automatic int ms_to_cycles(input int ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_event_gen_channel.sv
// One button channel: 2-FF synchroniser, debounce counter and the
// press / hold-to-repeat / release event FSM. All outputs are registered.
module button_event_gen_channel
    import button_event_gen_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = 20,
    parameter int REPEAT_RATE     = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic press,
    output logic rel
);

    localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RPT_MAX = max_int(REPEAT_DELAY, REPEAT_RATE);
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] DELAY_LOAD = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RATE_LOAD  = RPT_W'(REPEAT_RATE - 1);

    logic             sync_p0, sync_p1;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             level_q, level_d;
    logic [RPT_W-1:0] rep_cnt_q, rep_cnt_d;
    btn_state_t       state_q, state_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;
    logic             accept, rise, fall;

    // ---- stage p0/p1: bring the asynchronous button into the CLK domain
    // Two-flop synchroniser; cleared on reset so a held button is re-debounced.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= btn_raw;
            sync_p1 <= sync_p0;
        end
    end

    // ---- debounce: accept a new level after it has been stable long enough
    // Count consecutive cycles the synchronised input disagrees with the level.
    always_comb begin
        deb_cnt_d = '0;
        level_d   = level_q;
        accept    = 1'b0;
        if (sync_p1 != level_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                accept  = 1'b1;
                level_d = ~level_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end
    end

    assign rise = accept & ~level_q;
    assign fall = accept &  level_q;

    // ---- event FSM: press on rise, delayed then periodic repeats, release on fall
    // Next-state, repeat counter and pulse decode; a fall overrides everything.
    always_comb begin
        state_d   = state_q;
        rep_cnt_d = rep_cnt_q;
        press_d   = 1'b0;
        rel_d     = 1'b0;
        if (fall) begin
            state_d   = ST_IDLE;
            rep_cnt_d = '0;
            rel_d     = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        state_d   = ST_DELAY;
                        rep_cnt_d = DELAY_LOAD;
                        press_d   = 1'b1;
                    end
                end
                ST_DELAY: begin
                    // With repeats disabled the channel parks here until release.
                    if (REPEAT_EN != 0) begin
                        if (rep_cnt_q == '0) begin
                            state_d   = ST_REPEAT;
                            rep_cnt_d = RATE_LOAD;
                            press_d   = 1'b1;
                        end else begin
                            rep_cnt_d = rep_cnt_q - RPT_W'(1);
                        end
                    end
                end
                ST_REPEAT: begin
                    if (rep_cnt_q == '0) begin
                        rep_cnt_d = RATE_LOAD;
                        press_d   = 1'b1;
                    end else begin
                        rep_cnt_d = rep_cnt_q - RPT_W'(1);
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    rep_cnt_d = '0;
                end
            endcase
        end
    end

    // ---- output stage: register level, counters, state and pulses
    // State and output registers; reset takes priority over any event.
    always_ff @(posedge clk) begin
        if (rst) begin
            deb_cnt_q <= '0;
            level_q   <= 1'b0;
            rep_cnt_q <= '0;
            state_q   <= ST_IDLE;
            press_q   <= 1'b0;
            rel_q     <= 1'b0;
        end else begin
            deb_cnt_q <= deb_cnt_d;
            level_q   <= level_d;
            rep_cnt_q <= rep_cnt_d;
            state_q   <= state_d;
            press_q   <= press_d;
            rel_q     <= rel_d;
        end
    end

    assign level = level_q;
    assign press = press_q;
    assign rel   = rel_q;

endmodule

// File: rtl/button_event_gen.sv
// Button event generator top: N_BTN fully independent channels, each
// producing a debounced level plus press/repeat and release pulses.
module button_event_gen
    import button_event_gen_pkg::*;
#(
    parameter int N_BTN           = 2,
    parameter int DEBOUNCE_CYCLES = ms_to_cycles(10),
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = ms_to_cycles(500),
    parameter int REPEAT_RATE     = ms_to_cycles(100)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_BTN-1:0] BTN_IN,
    output logic [N_BTN-1:0] BTN_LEVEL,
    output logic [N_BTN-1:0] BTN_PRESS,
    output logic [N_BTN-1:0] BTN_RELEASE
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        button_event_gen_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_EN       (REPEAT_EN),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_RATE     (REPEAT_RATE)
        ) u_ch (
            .clk     (CLK),
            .rst     (RST),
            .btn_raw (BTN_IN[i]),
            .level   (BTN_LEVEL[i]),
            .press   (BTN_PRESS[i]),
            .rel     (BTN_RELEASE[i])
        );
    end

endmodule

// File: tb/tb_button_event_gen.sv
// Bench for button_event_gen: a directed stimulus/expectation table plus
// randomized stimulus checked every cycle against a timing-rule model.
module tb_button_event_gen;

    localparam int DEB = 4;
    localparam int RD  = 20;
    localparam int RR  = 8;

    logic       clk;
    logic       rst;
    logic [1:0] btn;
    logic [1:0] lvl_a, prs_a, rel_a;   // REPEAT_EN=1 instance
    logic [1:0] lvl_b, prs_b, rel_b;   // REPEAT_EN=0 instance

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    button_event_gen #(.N_BTN(2), .DEBOUNCE_CYCLES(DEB), .REPEAT_EN(1),
                       .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut_a (
        .CLK(clk), .RST(rst), .BTN_IN(btn),
        .BTN_LEVEL(lvl_a), .BTN_PRESS(prs_a), .BTN_RELEASE(rel_a));

    button_event_gen #(.N_BTN(2), .DEBOUNCE_CYCLES(DEB), .REPEAT_EN(0),
                       .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut_b (
        .CLK(clk), .RST(rst), .BTN_IN(btn),
        .BTN_LEVEL(lvl_b), .BTN_PRESS(prs_b), .BTN_RELEASE(rel_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state, indexed [variant][channel]; variant 0 repeats, 1 does not.
    bit m_s0   [2][2];
    bit m_s1   [2][2];
    bit m_lvl  [2][2];
    bit m_prs  [2][2];
    bit m_rel  [2][2];
    int m_run  [2][2];
    int m_held [2][2];

    typedef struct {
        int         cyc;
        logic       rst;
        logic [1:0] btn;
    } stim_t;

    typedef struct {
        int         cyc;
        logic [1:0] lvl, prs, rel, lvl_nr, prs_nr, rel_nr;
    } exp_t;

    stim_t stim_tab[$];
    exp_t  exp_tab[$];

    task automatic add_stim(input int c, input logic r, input logic [1:0] b);
        stim_t s;
        s.cyc = c; s.rst = r; s.btn = b;
        stim_tab.push_back(s);
    endtask

    task automatic add_exp(input int c, input logic [1:0] l, input logic [1:0] p,
                           input logic [1:0] r, input logic [1:0] ln,
                           input logic [1:0] pn, input logic [1:0] rn);
        exp_t e;
        e.cyc = c; e.lvl = l; e.prs = p; e.rel = r;
        e.lvl_nr = ln; e.prs_nr = pn; e.rel_nr = rn;
        exp_tab.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%b want=%b", nm, cyc, act, want);
        end
    endtask

    // Model: the level flips once the synchronised input (raw delayed two
    // edges) has disagreed with it for DEB consecutive cycles; presses fall
    // at hold time 0, RD, RD+RR, RD+2RR, ... measured from the accepted rise.
    task automatic model_edge(input int d, input int c, input bit raw, input bit rs);
        m_prs[d][c] = 1'b0;
        m_rel[d][c] = 1'b0;
        if (rs) begin
            m_s0[d][c] = 1'b0; m_s1[d][c] = 1'b0; m_lvl[d][c] = 1'b0;
            m_run[d][c] = 0;   m_held[d][c] = 0;
        end else begin
            m_run[d][c] = (m_s1[d][c] != m_lvl[d][c]) ? m_run[d][c] + 1 : 0;
            m_s1[d][c] = m_s0[d][c];
            m_s0[d][c] = raw;
            if (m_run[d][c] == DEB) begin
                m_run[d][c] = 0;
                m_lvl[d][c] = !m_lvl[d][c];
                if (m_lvl[d][c]) begin
                    m_prs[d][c]  = 1'b1;
                    m_held[d][c] = 0;
                end else begin
                    m_rel[d][c] = 1'b1;
                end
            end else if (m_lvl[d][c]) begin
                m_held[d][c]++;
                if (d == 0 && (m_held[d][c] == RD ||
                    (m_held[d][c] > RD && (m_held[d][c] - RD) % RR == 0)))
                    m_prs[d][c] = 1'b1;
            end
        end
    endtask

    task automatic step();
        logic [1:0] raw;
        logic       rs;
        logic [1:0] el, ep, er;
        raw = btn;
        rs  = rst;
        @(posedge clk);
        #1;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 2; c++) begin
                model_edge(d, c, raw[c], rs);
                el[c] = m_lvl[d][c];
                ep[c] = m_prs[d][c];
                er[c] = m_rel[d][c];
            end
            if (d == 0) begin
                chk("model_lvl_a", lvl_a, el);
                chk("model_prs_a", prs_a, ep);
                chk("model_rel_a", rel_a, er);
            end else begin
                chk("model_lvl_b", lvl_b, el);
                chk("model_prs_b", prs_b, ep);
                chk("model_rel_b", rel_b, er);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        btn = 2'b00;

        // Stimulus: value driven just after the edge that ends cycle 'cyc'.
        add_stim(0,   1'b1, 2'b00);
        add_stim(2,   1'b0, 2'b00);
        add_stim(10,  1'b0, 2'b01);   // press ch0, held
        add_stim(20,  1'b0, 2'b11);   // 3-cycle glitch on ch1
        add_stim(23,  1'b0, 2'b01);
        add_stim(70,  1'b0, 2'b00);   // release after repeats
        add_stim(90,  1'b0, 2'b01);   // short press, release in DELAY
        add_stim(100, 1'b0, 2'b00);
        add_stim(130, 1'b0, 2'b01);   // held through a reset mid-REPEAT
        add_stim(160, 1'b1, 2'b01);
        add_stim(162, 1'b0, 2'b01);
        add_stim(190, 1'b0, 2'b00);
        add_stim(210, 1'b0, 2'b11);   // both channels together
        add_stim(316, 1'b0, 2'b00);

        //      cyc  lvl    prs    rel    lvl_nr prs_nr rel_nr
        add_exp(1,   2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        add_exp(15,  2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        add_exp(16,  2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00);
        add_exp(17,  2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        add_exp(26,  2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        add_exp(36,  2'b01, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00);
        add_exp(37,  2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        add_exp(44,  2'b01, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00);
        add_exp(52,  2'b01, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00);
        add_exp(60,  2'b01, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00);
        add_exp(68,  2'b01, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00);
        add_exp(75,  2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        add_exp(76,  2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01);
        add_exp(77,  2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        add_exp(96,  2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00);
        add_exp(105, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        add_exp(106, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01);
        add_exp(116, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        add_exp(136, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00);
        add_exp(156, 2'b01, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00);
        add_exp(160, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        add_exp(161, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        add_exp(162, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        add_exp(164, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        add_exp(167, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        add_exp(168, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00);
        add_exp(188, 2'b01, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00);
        add_exp(196, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01);
        add_exp(216, 2'b11, 2'b11, 2'b00, 2'b11, 2'b11, 2'b00);
        add_exp(236, 2'b11, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00);
        add_exp(316, 2'b11, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00);
        add_exp(322, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11);

        // Directed run: apply table stimulus, compare table expectations.
        for (int k = 0; k < 330; k++) begin
            foreach (stim_tab[i]) begin
                if (stim_tab[i].cyc == k) begin
                    rst = stim_tab[i].rst;
                    btn = stim_tab[i].btn;
                end
            end
            step();
            foreach (exp_tab[i]) begin
                if (exp_tab[i].cyc == cyc) begin
                    chk("tab_lvl_a", lvl_a, exp_tab[i].lvl);
                    chk("tab_prs_a", prs_a, exp_tab[i].prs);
                    chk("tab_rel_a", rel_a, exp_tab[i].rel);
                    chk("tab_lvl_b", lvl_b, exp_tab[i].lvl_nr);
                    chk("tab_prs_b", prs_b, exp_tab[i].prs_nr);
                    chk("tab_rel_b", rel_b, exp_tab[i].rel_nr);
                end
            end
        end

        // Randomized run: mixed glitches, long holds and occasional resets.
        for (int seg = 0; seg < 60; seg++) begin
            int hold;
            btn = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) begin
                rst  = 1'b1;
                hold = $urandom_range(1, 3);
            end else begin
                rst  = 1'b0;
                hold = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5)
                                                   : $urandom_range(6, 45);
            end
            repeat (hold) step();
            rst = 1'b0;
        end
        repeat (10) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
